mdio_peripheral: RTL

Serial-to-register front end of the MDIO PHY side. It decodes Clause-22-style 32-bit MDIO frames driven by the station controller and converts them into single-cycle write strobes or registered reads on the PHY register file port (ADDR / WR_DATA / WR_STB / RD_DATA). For read frames it shifts the register contents back to the controller on MDIO_IN. It sits between the MDIO controller pins and the PHY register file.

---
 rtl/mdio_pkg.sv | 39 +++
 rtl/mdio_if.sv | 25 ++
 rtl/mdc_edge_detect.sv | 21 ++
 rtl/mdio_peripheral.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO PHY-side peripheral and its helpers.
package mdio_pkg;

    localparam int unsigned FRAME_BITS    = 32;
    localparam int unsigned HDR_LAST_BIT  = 13;
    localparam int unsigned TA_LAST_BIT   = 15;
    localparam int unsigned DATA_LAST_BIT = 31;
    localparam int unsigned CNT_W         = 5;
    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned HDR_W         = 14;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_CODE  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        TURNAROUND,
        WRITE_DATA,
        READ_DATA,
        SKIP
    } state_e;

    // Frame bits 0..13 as they sit in the shift register after edge 13
    typedef struct packed {
        logic [1:0]        st;
        logic [1:0]        op;
        logic [ADDR_W-1:0] phyad;
        logic [ADDR_W-1:0] regad;
    } mdio_hdr_t;

    function automatic logic hdr_accept(input mdio_hdr_t hdr, input logic [ADDR_W-1:0] phy);
        return (hdr.st == ST_CODE) && ((hdr.op == OP_WRITE) || (hdr.op == OP_READ))
               && (hdr.phyad == phy);
    endfunction

endpackage

// File: rtl/mdio_if.sv
// MDIO pins plus PHY register file port; slave is the peripheral's view.
interface mdio_if;
    import mdio_pkg::*;

    logic              MDC;
    logic              MDIO_OUT;
    logic              MDIO_OE;
    logic              MDIO_IN;
    logic              MDIO_IN_OE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_STB;
    logic [DATA_W-1:0] RD_DATA;

    modport master (
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        input  MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB
    );

    modport slave (
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        output MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB
    );

endinterface

// File: rtl/mdc_edge_detect.sv
// Samples MDC in the clk domain and flags its rising edge for one clk.
module mdc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic mdc_i,
    output logic rise_c_o
);

    logic mdc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc_i;
        end
    end

    assign rise_c_o = mdc_i & ~mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// Decodes Clause-22 MDIO frames into register-file writes and serial read-back.
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd0
) (
    input logic   clk,
    input logic   reset,
    mdio_if.slave bus
);

    logic mdc_rise;

    mdc_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .mdc_i    (bus.MDC),
        .rise_c_o (mdc_rise)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_stb_q, wr_stb_d;
    logic              mdio_in_q, mdio_in_d;
    logic              in_oe_q, in_oe_d;

    logic [DATA_W-1:0] sh_next;
    mdio_hdr_t         hdr;

    assign sh_next = {sh_q[DATA_W-2:0], bus.MDIO_OUT};
    assign hdr     = mdio_hdr_t'(sh_next[HDR_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            mdio_in_q <= 1'b0;
            in_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            mdio_in_q <= mdio_in_d;
            in_oe_q   <= in_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        mdio_in_d = mdio_in_q;
        in_oe_d   = in_oe_q;

        unique case (state_q)
            IDLE: begin
                if (mdc_rise && bus.MDIO_OE) begin
                    sh_d    = sh_next;
                    cnt_d   = CNT_W'(1);
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (!bus.MDIO_OE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (mdc_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(HDR_LAST_BIT)) begin
                        if (hdr_accept(hdr, PHY_ADDR)) begin
                            addr_d  = hdr.regad;
                            rd_d    = (hdr.op == OP_READ);
                            state_d = TURNAROUND;
                        end else begin
                            state_d = SKIP;
                        end
                    end
                end
            end
            TURNAROUND: begin
                if (mdc_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TA_LAST_BIT)) begin
                        if (rd_q) begin
                            // Preshifted so sh_q[MSB] always holds the next bit to drive
                            sh_d      = {bus.RD_DATA[DATA_W-2:0], 1'b0};
                            mdio_in_d = bus.RD_DATA[DATA_W-1];
                            state_d   = READ_DATA;
                        end else begin
                            state_d = WRITE_DATA;
                        end
                    end else if (rd_q) begin
                        in_oe_d   = 1'b1;
                        mdio_in_d = 1'b0;
                    end
                end
            end
            WRITE_DATA: begin
                if (!bus.MDIO_OE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (mdc_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_LAST_BIT)) begin
                        wr_data_d = sh_next;
                        wr_stb_d  = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            READ_DATA: begin
                if (mdc_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_LAST_BIT)) begin
                        mdio_in_d = 1'b0;
                        in_oe_d   = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        mdio_in_d = sh_q[DATA_W-1];
                        sh_d      = {sh_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            SKIP: begin
                if (mdc_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_LAST_BIT)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ADDR       = addr_q;
    assign bus.WR_DATA    = wr_data_q;
    assign bus.WR_STB     = wr_stb_q;
    assign bus.MDIO_IN    = mdio_in_q;
    assign bus.MDIO_IN_OE = in_oe_q;

endmodule
